// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state type for the slice-serial ALU.
package alu_pkg;

   localparam logic [1:0] FN_AND = 2'b00;
   localparam logic [1:0] FN_OR  = 2'b01;
   localparam logic [1:0] FN_ADD = 2'b10;
   localparam logic [1:0] FN_SLT = 2'b11;

   localparam int unsigned OP_AINV = 3;
   localparam int unsigned OP_BINV = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } alu_state_t;

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit AND/OR/ADD slice with operand inversion.
module alu_slice
   import alu_pkg::*;
#(
   parameter int unsigned SLICE = 8
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             ainv,
   input  logic             binv,
   input  logic [1:0]       fn,
   input  logic             cin,
   output logic [SLICE-1:0] result,
   output logic             cout,
   output logic             c_msb,
   output logic             sum_msb
);

   logic [SLICE-1:0] a_eff;
   logic [SLICE-1:0] b_eff;
   logic [SLICE:0]   sum;

   // Effective operands, ripple sum and per-function result select.
   always_comb begin
      a_eff   = ainv ? ~a : a;
      b_eff   = binv ? ~b : b;
      sum     = {1'b0, a_eff} + {1'b0, b_eff} + (SLICE+1)'(cin);
      cout    = sum[SLICE];
      sum_msb = sum[SLICE-1];
      // Carry into the top bit recovered from the sum and operand bits.
      c_msb   = sum[SLICE-1] ^ a_eff[SLICE-1] ^ b_eff[SLICE-1];
      result  = sum[SLICE-1:0];
      case (fn)
         FN_AND:  result = a_eff & b_eff;
         FN_OR:   result = a_eff | b_eff;
         default: result = sum[SLICE-1:0];
      endcase
   end

endmodule

// File: rtl/slice_serial_alu.sv
// Multi-cycle ALU processing SLICE bits per clock, LSB slice first.
module slice_serial_alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             zero,
   output logic             overflow
);

   localparam int unsigned N     = (SLICE > 0) ? WIDTH / SLICE : 1;
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

   if (SLICE < 1) begin : g_bad_slice
      $error("slice_serial_alu: SLICE must be at least 1");
   end else if (WIDTH % SLICE != 0) begin : g_bad_width
      $error("slice_serial_alu: WIDTH must be a multiple of SLICE");
   end

   alu_state_t       state, state_nxt;
   logic             accept, step, last;
   logic [CNT_W-1:0] cnt;
   logic             carry_q;
   logic             zero_q;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] a_sh, b_sh, res_sh;

   logic [SLICE-1:0] s_res;
   logic             s_cout, s_cmsb, s_sum_msb;
   logic [WIDTH-1:0] res_full;
   logic             ovf, set, arith, is_slt, zero_nxt;

   alu_slice #(.SLICE(SLICE)) u_slice (
      .a       (a_sh[SLICE-1:0]),
      .b       (b_sh[SLICE-1:0]),
      .ainv    (op_q[OP_AINV]),
      .binv    (op_q[OP_BINV]),
      .fn      (op_q[1:0]),
      .cin     (carry_q),
      .result  (s_res),
      .cout    (s_cout),
      .c_msb   (s_cmsb),
      .sum_msb (s_sum_msb)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state, handshake and datapath strobes.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      accept    = 1'b0;
      step      = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == CNT_W'(N - 1)) begin
               last      = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               in_ready = 1'b1;
               if (in_valid) begin
                  accept    = 1'b1;
                  state_nxt = RUN;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign out_valid = (state == DONE);

   // Per-slice combining: shift result in from the top, derive final flags.
   always_comb begin
      res_full = WIDTH'({s_res, res_sh} >> SLICE);
      ovf      = s_cmsb ^ s_cout;
      set      = s_sum_msb ^ ovf;
      arith    = op_q[1];
      is_slt   = (op_q[1:0] == FN_SLT);
      zero_nxt = zero_q & ~(|s_res);
   end

   // Operand/accumulator shifting and result/flag capture on DONE entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         op_q     <= '0;
         a_sh     <= '0;
         b_sh     <= '0;
         res_sh   <= '0;
         result   <= '0;
         cout     <= 1'b0;
         zero     <= 1'b0;
         overflow <= 1'b0;
      end else if (accept) begin
         a_sh    <= a;
         b_sh    <= b;
         op_q    <= op;
         cnt     <= '0;
         carry_q <= op[OP_BINV];
         zero_q  <= 1'b1;
      end else if (step) begin
         a_sh    <= a_sh >> SLICE;
         b_sh    <= b_sh >> SLICE;
         res_sh  <= res_full;
         carry_q <= s_cout;
         zero_q  <= zero_nxt;
         cnt     <= cnt + CNT_W'(1);
         if (last) begin
            result   <= is_slt ? WIDTH'(set) : res_full;
            cout     <= arith & s_cout;
            overflow <= arith & ovf;
            zero     <= is_slt ? ~set : zero_nxt;
         end
      end
   end

endmodule

// File: tb/tb_slice_serial_alu.sv
// Self-checking bench for slice_serial_alu at WIDTH=32, SLICE=8.
module tb_slice_serial_alu;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned SLICE = 8;
   localparam int LAT = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  a, b;
   logic [3:0]        op;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  result;
   logic              cout, zero, overflow;

   int n_tests = 0;
   int n_fail  = 0;

   logic [34:0] exp_q;

   always #5 clk = ~clk;

   slice_serial_alu #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .zero      (zero),
      .overflow  (overflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference: {overflow, zero, cout, result} from plain 33-bit arithmetic.
   function automatic logic [34:0] model(input logic [31:0] a_i, input logic [31:0] b_i,
                                         input logic [3:0] op_i);
      logic [31:0] ae, be, r;
      logic [32:0] s;
      logic        c, v, z;
      ae = op_i[3] ? ~a_i : a_i;
      be = op_i[2] ? ~b_i : b_i;
      s  = {1'b0, ae} + {1'b0, be} + 33'(op_i[2]);
      c  = 1'b0;
      v  = 1'b0;
      case (op_i[1:0])
         2'b00:   r = ae & be;
         2'b01:   r = ae | be;
         default: begin
            c = s[32];
            v = (ae[31] == be[31]) && (s[31] != ae[31]);
            r = s[31:0];
            if (op_i[1:0] == 2'b11) r = {31'b0, s[31] ^ v};
         end
      endcase
      z = (r == 32'd0);
      return {v, z, c, r};
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, "_result"},   result,                 exp_q[31:0]);
      check({tag, "_cout"},     32'(cout),              32'(exp_q[32]));
      check({tag, "_zero"},     32'(zero),              32'(exp_q[33]));
      check({tag, "_overflow"}, 32'(overflow),          32'(exp_q[34]));
   endtask

   // Called #1 after a rising edge; releases any pending result at the same time.
   task automatic accept_op(input logic [31:0] a_i, input logic [31:0] b_i, input logic [3:0] op_i);
      a         = a_i;
      b         = b_i;
      op        = op_i;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      check("in_ready_at_accept", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = $urandom;
      b         = $urandom;
      op        = 4'($urandom);
      check("out_valid_after_accept", 32'(out_valid), 32'd0);
      exp_q = model(a_i, b_i, op_i);
   endtask

   task automatic wait_result(input int hold);
      int lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      check("latency", 32'(lat), 32'(LAT));
      check("in_ready_in_done", 32'(in_ready), 32'd0);
      check_outputs("res");
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         check("hold_out_valid", 32'(out_valid), 32'd1);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         check_outputs("hold");
      end
   endtask

   task automatic release_idle();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("idle_out_valid", 32'(out_valid), 32'd0);
      check("idle_in_ready", 32'(in_ready), 32'd1);
   endtask

   logic [31:0] dir_a  [6] = '{32'd5, 32'h12345678, 32'hFFFFFFFD, 32'd2, 32'h7FFFFFFF, 32'd0};
   logic [31:0] dir_b  [6] = '{32'd7, 32'h12345678, 32'd2, 32'hFFFFFFFD, 32'd1, 32'd0};
   logic [3:0]  dir_op [6] = '{4'b0010, 4'b0110, 4'b0111, 4'b0111, 4'b0010, 4'b1100};

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      op        = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result",    result,         32'd0);
      check("rst_flags",     32'({cout, zero, overflow}), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Directed cases; each later accept happens back-to-back from DONE.
      for (int i = 0; i < 6; i++) begin
         accept_op(dir_a[i], dir_b[i], dir_op[i]);
         wait_result((i == 0) ? 3 : 1);
      end
      release_idle();

      // Randomized operations with random backpressure and idle gaps.
      for (int i = 0; i < 40; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
         accept_op(ra, rb, 4'($urandom));
         wait_result(int'($urandom_range(0, 2)));
         if ($urandom_range(0, 2) == 0) release_idle();
      end
      release_idle();

      // Reset in flight after the second slice edge.
      accept_op(32'h0000FFFF, 32'h00000001, 4'b0010);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_result",    result,         32'd0);
      check("midrst_in_ready",  32'(in_ready),  32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         check("no_stale_out_valid", 32'(out_valid), 32'd0);
      end

      accept_op(32'd100, 32'd58, 4'b0110);
      wait_result(0);
      release_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
